// File: rtl/multiword_select_adder_seq.sv
// Multi-word adder sequencer: feeds one 16-bit chunk per clock to an external
// 16-bit carry-select adder, least significant chunk first, and assembles the W-bit result.
module multiword_select_adder_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   op_a,
    input  logic [16*WORDS-1:0]   op_b,
    input  logic                  op_cin,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_s,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout
);

    localparam int W    = 16 * WORDS;
    localparam int CW   = 16;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IDXW-1:0]   idx_r;
    logic              carry_r;
    logic [W-1:0]      opa_r;
    logic [W-1:0]      opb_r;
    logic [W-1:0]      sum_r;
    logic              cout_r;
    logic              out_valid_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              last_s;
    logic [CW-1:0]     add_a_s;
    logic [CW-1:0]     add_b_s;
    logic              add_cin_s;

    function automatic logic [CW-1:0] chunk_sel(input logic [W-1:0] vec, input logic [IDXW-1:0] idx);
        return vec[CW*idx +: CW];
    endfunction

    assign last_s   = (idx_r == LAST_IDX);
    assign accept_s = in_valid & in_ready_s;

    // Next-state decode plus handshake and adder-operand drive.
    always_comb begin
        state_nxt_s = state_r;
        in_ready_s  = 1'b0;
        add_a_s     = {CW{1'b0}};
        add_b_s     = {CW{1'b0}};
        add_cin_s   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                add_a_s   = chunk_sel(opa_r, idx_r);
                add_b_s   = chunk_sel(opb_r, idx_r);
                add_cin_s = carry_r;
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                // A consumed result frees the slot in the same cycle, so a new request can enter.
                if (out_ready) begin
                    in_ready_s = 1'b1;
                    if (in_valid) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, chunk-by-chunk sum assembly and inter-chunk carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r   <= {W{1'b0}};
            opb_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
            sum_r   <= {W{1'b0}};
            cout_r  <= 1'b0;
        end else if (accept_s) begin
            opa_r   <= op_a;
            opb_r   <= op_b;
            carry_r <= op_cin;
            idx_r   <= {IDXW{1'b0}};
        end else if (state_r == RUN) begin
            sum_r[CW*idx_r +: CW] <= add_s;
            carry_r               <= add_cout;
            // idx parks on the last chunk so it never wraps inside an operation.
            if (last_s) begin
                cout_r <= add_cout;
            end else begin
                idx_r <= idx_r + IDXW'(1);
            end
        end
    end

    // Result-valid flag: raised after the last chunk, dropped when consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if ((state_r == RUN) && last_s) begin
            out_valid_r <= 1'b1;
        end else if ((state_r == DONE) && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign add_a     = add_a_s;
    assign add_b     = add_b_s;
    assign add_cin   = add_cin_s;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_multiword_select_adder_seq.sv
// Self-checking bench for multiword_select_adder_seq (WORDS=4) with a 16-bit
// carry-select adder as datapath and a plain-arithmetic 65-bit reference.
`timescale 1ns/1ps
module tb_multiword_select_adder_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        op_cin;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_s;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;

    int tests = 0;
    int fails = 0;

    multiword_select_adder_seq #(.WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    // 16-bit carry-select adder: 8-bit low ripple, high byte precomputed for both carries.
    logic [8:0] lo_s;
    logic [8:0] hi0_s;
    logic [8:0] hi1_s;
    assign lo_s     = {1'b0, add_a[7:0]} + {1'b0, add_b[7:0]} + {8'd0, add_cin};
    assign hi0_s    = {1'b0, add_a[15:8]} + {1'b0, add_b[15:8]};
    assign hi1_s    = {1'b0, add_a[15:8]} + {1'b0, add_b[15:8]} + 9'd1;
    assign add_s    = {(lo_s[8] ? hi1_s[7:0] : hi0_s[7:0]), lo_s[7:0]};
    assign add_cout = lo_s[8] ? hi1_s[8] : hi0_s[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {64'd0, c};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request from a negedge; returns at the negedge after the handshake edge.
    task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic c);
        bit ok;
        ok = 1'b0;
        op_a = a; op_b = b; op_cin = c; in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("accept_timeout", {64'd0, ok}, 65'd1);
        chk("first_chunk_a", {49'd0, add_a}, {49'd0, a[15:0]});
        chk("first_chunk_cin", {64'd0, add_cin}, {64'd0, c});
    endtask

    // Counts clock edges from the handshake edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("latency", 65'(lat), 65'd4);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("retire_valid_low", {64'd0, out_valid}, 65'd0);
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic c);
        int lat;
        accept(a, b, c);
        wait_result(lat);
        chk(tag, {cout, sum}, ref_add(a, b, c));
    endtask

    logic [63:0] va [3];
    logic [63:0] vb [3];
    logic        vc [3];
    logic [64:0] held;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    int          lat;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = 64'd0; op_b = 64'd0; op_cin = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", {64'd0, in_ready}, 65'd1);
        chk("rst_add_a", {49'd0, add_a}, 65'd0);
        chk("rst_add_b", {49'd0, add_b}, 65'd0);
        chk("rst_add_cin", {64'd0, add_cin}, 65'd0);
        chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
        chk("rst_result", {cout, sum}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full carry ripple across every chunk.
        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        chk("ripple_const", {cout, sum}, {1'b1, 64'd0});
        retire();

        run_op("nines", 64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999, 1'b0);
        chk("nines_const", {cout, sum}, {1'b1, 64'h3333_3333_3333_3332});
        retire();

        run_op("cin_only", 64'd0, 64'd0, 1'b1);
        chk("cin_only_const", {cout, sum}, 65'd1);
        retire();

        // Backpressure: result held, new request stalled, adder inputs quiet.
        run_op("bp_op", 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1);
        held = ref_add(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1);
        op_a = 64'hAAAA_AAAA_AAAA_AAAA; op_b = 64'h5555_5555_5555_5555; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", {64'd0, in_ready}, 65'd0);
            chk("bp_add", {16'd0, add_a, add_b, add_cin}, 65'd0);
            chk("bp_valid", {64'd0, out_valid}, 65'd1);
            chk("bp_hold", {cout, sum}, held);
            @(negedge clk);
        end
        in_valid = 1'b0;
        retire();
        #1 chk("bp_idle_ready", {64'd0, in_ready}, 65'd1);
        @(negedge clk);

        // Back-to-back: retire and accept in the same DONE cycle.
        va[0] = 64'h0000_FFFF_0000_FFFF; vb[0] = 64'h0000_0001_0000_0001; vc[0] = 1'b0;
        va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'h8000_0000_0000_0000; vc[1] = 1'b1;
        va[2] = 64'h0123_4567_89AB_CDEF; vb[2] = 64'hFFFF_0000_FFFF_0000; vc[2] = 1'b1;
        out_ready = 1'b1;
        accept(va[0], vb[0], vc[0]);
        for (int j = 0; j < 3; j++) begin
            wait_result(lat);
            chk("b2b_result", {cout, sum}, ref_add(va[j], vb[j], vc[j]));
            if (j < 2) begin
                op_a = va[j+1]; op_b = vb[j+1]; op_cin = vc[j+1]; in_valid = 1'b1;
                #1 chk("b2b_in_ready", {64'd0, in_ready}, 65'd1);
                @(posedge clk);
                @(negedge clk);
                chk("b2b_no_bubble", {64'd0, out_valid}, 65'd0);
                chk("b2b_chunk0", {49'd0, add_a}, {49'd0, va[j+1][15:0]});
            end
        end
        in_valid = 1'b0;
        retire();

        // Reset after the second RUN cycle aborts the operation.
        accept(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {64'd0, out_valid}, 65'd0);
        chk("abort_result", {cout, sum}, 65'd0);
        chk("abort_in_ready", {64'd0, in_ready}, 65'd1);
        chk("abort_add", {16'd0, add_a, add_b, add_cin}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_abort", 64'hDEAD_BEEF_CAFE_F00D, 64'h0BAD_F00D_1234_5678, 1'b0);
        retire();

        // Randomised operands with random request and consume gaps.
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            if ($urandom_range(0, 9) == 0) rb = ~ra;
            run_op("random", ra, rb, rc);
            held = ref_add(ra, rb, rc);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("random_hold", {cout, sum}, held);
            end
            retire();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
